// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key event decoder: prefix FSM states,
// scan-code prefix and filter constants, and the event entry width.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Keyboard housekeeping bytes that never represent a key in IDLE
  localparam logic [7:0] FLT_ERR0   = 8'h00;
  localparam logic [7:0] FLT_BAT    = 8'hAA;
  localparam logic [7:0] FLT_ECHO   = 8'hEE;
  localparam logic [7:0] FLT_ACK    = 8'hFA;
  localparam logic [7:0] FLT_RESEND = 8'hFE;
  localparam logic [7:0] FLT_ERR1   = 8'hFF;

  // Event entry layout: {ext, brk, code[7:0]}
  localparam int ENTRY_W = 10;

  function automatic logic is_filter(input logic [7:0] b);
    return (b == FLT_ERR0) || (b == FLT_BAT) || (b == FLT_ECHO) ||
           (b == FLT_ACK) || (b == FLT_RESEND) || (b == FLT_ERR1);
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational scan-code set 2 to ASCII lookup (letters, digits,
// space, enter, backspace); anything else maps to 0x00.
module ps2_ascii_rom (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  // Lookup table
  always_comb begin
    ascii_o = 8'h00;
    case (code_i)
      8'h1C: ascii_o = 8'h61; 8'h32: ascii_o = 8'h62; 8'h21: ascii_o = 8'h63;
      8'h23: ascii_o = 8'h64; 8'h24: ascii_o = 8'h65; 8'h2B: ascii_o = 8'h66;
      8'h34: ascii_o = 8'h67; 8'h33: ascii_o = 8'h68; 8'h43: ascii_o = 8'h69;
      8'h3B: ascii_o = 8'h6A; 8'h42: ascii_o = 8'h6B; 8'h4B: ascii_o = 8'h6C;
      8'h3A: ascii_o = 8'h6D; 8'h31: ascii_o = 8'h6E; 8'h44: ascii_o = 8'h6F;
      8'h4D: ascii_o = 8'h70; 8'h15: ascii_o = 8'h71; 8'h2D: ascii_o = 8'h72;
      8'h1B: ascii_o = 8'h73; 8'h2C: ascii_o = 8'h74; 8'h3C: ascii_o = 8'h75;
      8'h2A: ascii_o = 8'h76; 8'h1D: ascii_o = 8'h77; 8'h22: ascii_o = 8'h78;
      8'h35: ascii_o = 8'h79; 8'h1A: ascii_o = 8'h7A;
      8'h45: ascii_o = 8'h30; 8'h16: ascii_o = 8'h31; 8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33; 8'h25: ascii_o = 8'h34; 8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36; 8'h3D: ascii_o = 8'h37; 8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      8'h29: ascii_o = 8'h20; 8'h5A: ascii_o = 8'h0D; 8'h66: ascii_o = 8'h08;
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scan-code byte stream to key events: a prefix FSM folds E0/F0
// prefixes into ext/brk flags and pushes {ext,brk,code} into a
// first-word-fall-through FIFO with a sticky overflow flag.
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done_tick,
  input  logic [7:0]               rx_data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_break,
  output logic [7:0]               ev_ascii,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t               state_q, state_d;
  logic                 emit, emit_ext, emit_brk;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 full, empty, pop, push_ok;
  logic [ENTRY_W-1:0]   head;
  logic [7:0]           rom_ascii;

  // Prefix FSM state register; reset drops any pending prefix
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Prefix FSM next state and event emission
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (rx_data == PFX_EXT)      state_d = EXT;
          else if (rx_data == PFX_BRK) state_d = BRK;
          else if (!is_filter(rx_data)) emit = 1'b1;
        end
        EXT: begin
          if (rx_data == PFX_BRK) state_d = EXT_BRK;
          else if (rx_data != PFX_EXT) begin
            emit = 1'b1; emit_ext = 1'b1; state_d = IDLE;
          end
        end
        BRK: begin
          if (rx_data == PFX_EXT) state_d = EXT_BRK;
          else if (rx_data != PFX_BRK) begin
            emit = 1'b1; emit_brk = 1'b1; state_d = IDLE;
          end
        end
        EXT_BRK: begin
          if (rx_data != PFX_EXT && rx_data != PFX_BRK) begin
            emit = 1'b1; emit_ext = 1'b1; emit_brk = 1'b1; state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = ev_valid && ev_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push_ok = emit && (!full || pop);

  // FIFO pointer/count/overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (emit && full && !pop);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are only observed through the non-empty gate
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {emit_ext, emit_brk, rx_data};
  end

  assign head       = empty ? '0 : mem_q[rd_ptr_q];
  assign ev_valid   = !empty;
  assign ev_ext     = head[9];
  assign ev_break   = head[8];
  assign ev_code    = head[7:0];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  ps2_ascii_rom u_rom (
    .code_i  (ev_code),
    .ascii_o (rom_ascii)
  );

  assign ev_ascii = ev_ext ? 8'h00 : rom_ascii;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event with an event scoreboard queue.
module tb_ps2_key_event;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ev_t;

  logic       clk, reset, rx_done_tick, ev_ready;
  logic [7:0] rx_data;
  logic       ev_valid, ev_ext, ev_break, overflow;
  logic [7:0] ev_code, ev_ascii;
  logic [2:0] fifo_count;

  int  checks = 0;
  int  errors = 0;
  ev_t sb[$];

  ps2_key_event #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_break     (ev_break),
    .ev_ascii     (ev_ascii),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; the byte is sampled on the following posedge
  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext,
                           input logic brk, input logic [7:0] ascii);
    ev_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.ascii = ascii;
    sb.push_back(e);
  endtask

  task automatic check_head(input string tag);
    ev_t e;
    check({tag, "_valid"}, ev_valid, 1);
    check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb[0];
      check({tag, "_code"},  ev_code,  e.code);
      check({tag, "_ext"},   ev_ext,   e.ext);
      check({tag, "_brk"},   ev_break, e.brk);
      check({tag, "_ascii"}, ev_ascii, e.ascii);
    end
  endtask

  // Wait (bounded) for an event, compare it with the scoreboard, pop it
  task automatic pop_check(input string tag);
    for (int i = 0; i < 20 && !ev_valid; i++) @(negedge clk);
    check_head(tag);
    if (sb.size() > 0) void'(sb.pop_front());
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00; ev_ready = 1'b0;
    #12;
    check("rst_valid", ev_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_code",  ev_code, 0);
    check("rst_ext",   ev_ext, 0);
    check("rst_brk",   ev_break, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Plain make code, event visible one cycle after the strobe
    expect_ev(8'h1C, 0, 0, 8'h61);
    send_byte(8'h1C);
    check("lat_valid", ev_valid, 1);
    pop_check("make_a");
    check("empty_after_pop", ev_valid, 0);

    // Break code
    send_byte(8'hF0);
    check("no_ev_on_f0", ev_valid, 0);
    expect_ev(8'h1C, 0, 1, 8'h61);
    send_byte(8'h1C);
    pop_check("break_a");

    // Extended break
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("no_ev_on_prefixes", ev_valid, 0);
    expect_ev(8'h75, 1, 1, 8'h00);
    send_byte(8'h75);
    pop_check("ext_break");

    // Extended make of a mapped code still gives ascii 0
    expect_ev(8'h5A, 1, 0, 8'h00);
    send_byte(8'hE0);
    send_byte(8'h5A);
    pop_check("ext_make");

    // Filter byte in IDLE vs after a prefix
    send_byte(8'hAA);
    @(negedge clk);
    check("aa_filtered", ev_valid, 0);
    check("aa_count", fifo_count, 0);
    expect_ev(8'hAA, 0, 1, 8'h00);
    send_byte(8'hF0);
    send_byte(8'hAA);
    pop_check("aa_after_brk");

    // Reset in the middle of a prefix
    send_byte(8'hE0);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    expect_ev(8'h1C, 0, 0, 8'h61);
    send_byte(8'h1C);
    pop_check("post_rst");

    // Overflow: five makes with no consumer
    expect_ev(8'h1C, 0, 0, 8'h61);
    expect_ev(8'h32, 0, 0, 8'h62);
    expect_ev(8'h21, 0, 0, 8'h63);
    expect_ev(8'h23, 0, 0, 8'h64);
    send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21);
    send_byte(8'h23); send_byte(8'h24);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    @(negedge clk); @(negedge clk);
    check("hold_code", ev_code, 8'h1C);
    for (int i = 0; i < 4; i++) pop_check("drain");
    check("drained_count", fifo_count, 0);
    check("ovf_sticky", overflow, 1);

    // Clear via reset, then full FIFO with simultaneous push and pop
    reset = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow, 0);
    reset = 1'b1;
    @(negedge clk);
    expect_ev(8'h45, 0, 0, 8'h30);
    expect_ev(8'h16, 0, 0, 8'h31);
    expect_ev(8'h29, 0, 0, 8'h20);
    expect_ev(8'h5A, 0, 0, 8'h0D);
    send_byte(8'h45); send_byte(8'h16); send_byte(8'h29); send_byte(8'h5A);
    check("full_count", fifo_count, 4);
    check_head("full_head");
    ev_ready     = 1'b1;
    rx_data      = 8'h66;
    rx_done_tick = 1'b1;
    @(negedge clk);
    ev_ready     = 1'b0;
    rx_done_tick = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    expect_ev(8'h66, 0, 0, 8'h08);
    check("pushpop_count", fifo_count, 4);
    check("pushpop_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) pop_check("wrap_drain");
    check("final_count", fifo_count, 0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_event.md
PS2_KEY_EVENT -- requirements
Module: ps2_key_event

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_done_tick  input  1  one-cycle strobe from the PS/2 receiver: byte valid.
REQ-005 SHALL have port rx_data  input  8  received scan-code byte, sampled only when rx_done_tick=1.
REQ-006 SHALL have port ev_valid  output  1  FIFO non-empty, head event presented.
REQ-007 SHALL have port ev_ready  input  1  consumer accepts head event when ev_valid=1.
REQ-008 SHALL have port ev_code  output  8  head event base scan code.
REQ-009 SHALL have port ev_ext  output  1  head event was E0-prefixed.
REQ-010 SHALL have port ev_break  output  1  head event is key release (F0-prefixed).
REQ-011 SHALL have port ev_ascii  output  8  ASCII of head event, 0x00 if ext or unmapped.
REQ-012 SHALL have port fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-014 Prefix FSM states SHALL be IDLE, EXT, BRK, EXT_BRK; all transitions occur only on rx_done_tick=1.
REQ-015 IDLE: 0xE0->EXT; 0xF0->BRK; 0x00/0xAA/0xEE/0xFA/0xFE/0xFF discarded, stay IDLE; other byte -> emit {ext=0,brk=0,code}, stay IDLE.
REQ-016 EXT: 0xF0->EXT_BRK; 0xE0 stays EXT; other -> emit {ext=1,brk=0,code}, ->IDLE.
REQ-017 BRK: 0xE0->EXT_BRK; 0xF0 stays BRK; other -> emit {ext=0,brk=1,code}, ->IDLE.
REQ-018 EXT_BRK: 0xE0/0xF0 stay; other -> emit {ext=1,brk=1,code}, ->IDLE.
REQ-019 Filter bytes of REQ-015 SHALL be discarded only in IDLE; in other states they are treated as base codes.
REQ-020 Emitted event SHALL be pushed into a FIFO of DEPTH 10-bit entries {ext,brk,code}, first-word-fall-through.
REQ-021 Latency: rx_done_tick in cycle N with empty FIFO SHALL give ev_valid=1 with event fields in cycle N+1.
REQ-022 Pop SHALL occur on the clock edge where ev_valid=1 and ev_ready=1; ev_* hold stable while ev_valid=1 and ev_ready=0.
REQ-023 Push when full SHALL be accepted if a pop occurs the same cycle; otherwise event dropped, overflow set to 1, FIFO unchanged.
REQ-024 Simultaneous push and pop on non-empty FIFO SHALL leave fifo_count unchanged; read/write pointers wrap modulo DEPTH.
REQ-025 ev_ascii SHALL be combinational from head entry; mapping covers a-z make/break codes (e.g. 0x1C->0x61), digits 0-9 (0x45->0x30), 0x29->0x20, 0x5A->0x0D, 0x66->0x08; all else 0x00.
REQ-026 overflow SHALL clear only by reset.

Reset
REQ-027 reset=0 SHALL immediately force FSM to IDLE, FIFO empty (pointers 0), fifo_count=0, ev_valid=0, overflow=0.
REQ-028 Reset asserted mid-prefix SHALL discard the pending prefix; the next byte after release is decoded from IDLE.
REQ-029 ev_code/ev_ext/ev_break SHALL read 0 while FIFO empty after reset.

Structure
REQ-030 Shared package ps2_pkg SHALL hold FSM state typedef, prefix constants (0xE0, 0xF0), filter-byte constants, and the event entry width (10).
REQ-031 ASCII mapping SHALL be a separate combinational sub-module ps2_ascii_rom (8-bit code in, 8-bit ASCII out).

Verification
REQ-032 Bytes 0x1C -> one event code=0x1C ext=0 brk=0 ascii=0x61 at N+1.
REQ-033 Bytes 0xF0,0x1C -> one event code=0x1C brk=1 ext=0; no event on 0xF0.
REQ-034 Bytes 0xE0,0xF0,0x75 -> one event code=0x75 ext=1 brk=1 ascii=0x00.
REQ-035 ev_ready=0, five makes with DEPTH=4 -> fifo_count=4, overflow=1, then draining yields the first four codes in order.
REQ-036 0xAA in IDLE -> no event; 0xE0 then reset pulse then 0x1C -> event ext=0.
REQ-037 Full FIFO, push and pop same cycle -> fifo_count stays 4, overflow stays 0.
